imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the 32 x 8-bit instruction memory. It accepts a framed byte stream (length, payload, checksum) over a valid/ready handshake and writes the payload into consecutive instruction addresses starting at 0. It holds the CPU in reset until a load completes with a good checksum. It sits between the host/debug byte source and the write port of the writable instruction RAM.

## Interface
Parameters:
- DEPTH, 32: instruction memory words.
- ADDR_W, 5: instruction address width.
- DATA_W, 8: instruction width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- in_valid  input  1  source has a byte on in_data.
- in_data  input  DATA_W  stream byte.
- in_ready  output  1  loader accepts a byte; registered.
- wr_en  output  1  instruction RAM write strobe; registered.
- wr_addr  output  ADDR_W  RAM write address; registered.
- wr_data  output  DATA_W  RAM write data; registered.
- cpu_rst  output  1  holds the CPU in reset; low only in DONE.
- done  output  1  load completed, checksum good.
- err  output  1  load aborted: bad length or checksum mismatch.
- count  output  ADDR_W+1  payload bytes written in the current or last load.

## Operation
- A byte is accepted on a rising edge where in_valid and in_ready are both high.
- States and transitions:
  - IDLE: goes to LEN on start.
  - LEN: accepts the length byte N.
    - N in 1..DEPTH: go to DATA; clear the XOR accumulator and count.
    - N = 0 or N > DEPTH: go to ERR.
  - DATA: accepts payload bytes.
    - Each accepted byte b is written to address count, with data b.
    - The accumulator becomes acc ^ b, and count increments.
    - After the N-th byte, go to CSUM.
  - CSUM: accepts one byte.
    - Byte equals acc: go to DONE.
    - Otherwise: go to ERR.
  - DONE / ERR: both are terminal. start re-enters LEN, clears count, and clears done/err.
- in_ready is high in LEN, DATA and CSUM, and low elsewhere.
- Only payload bytes produce writes. Addresses N..DEPTH-1 are left untouched.
- start outside IDLE/DONE/ERR is ignored.
- start and in_valid in the same IDLE cycle: no byte is accepted (in_ready is low). The byte is taken in LEN on the next cycle if still valid.
- count saturates by construction at N ≤ DEPTH; the address never wraps.
- Reset values: state = IDLE, in_ready = 0, wr_en = 0, wr_addr = 0, wr_data = 0, cpu_rst = 1, done = 0, err = 0, count = 0, acc = 0.
- Reset mid-load returns to IDLE with the reset values above. Partially written RAM contents are not cleared.

## Timing
- Write latency is 1 cycle. A payload byte accepted at edge k gives wr_en/wr_addr/wr_data valid for exactly the cycle following edge k.
- Back-to-back acceptance is supported: one byte per cycle, so N payload bytes give N consecutive wr_en cycles.
- The in_ready change at a state transition takes effect the cycle after the transition edge.
  - Example: the accepting edge of the checksum byte drops in_ready for the next cycle.
- done, err and cpu_rst are registered and update on the edge that accepts the final (checksum or length) byte.
  - cpu_rst falls on the same edge that done rises.
- Minimum load time: 1 cycle for start, then N + 2 cycles of accepted bytes.

## Structure
- Shared package/header (imem_pkg):
  - DEPTH, ADDR_W, DATA_W.
  - State encodings: IDLE, LEN, DATA, CSUM, DONE, ERR (3-bit).
- Single module, with no sub-modules.
- The writable instruction RAM is a separate block fed by wr_en/wr_addr/wr_data.
- The checksum is an inline 8-bit XOR register.

## Test plan
- **Reset:** assert rst asynchronously mid-cycle → in_ready = 0, wr_en = 0, cpu_rst = 1, done = err = 0, count = 0 immediately.
- **Good load:**
  - Stimulus: start, then stream 03, 0B, 49, 12, csum 50, with in_valid held high.
  - Writes: (0, 0B), (1, 49), (2, 12) on 3 consecutive cycles.
  - Result: done = 1, cpu_rst = 0, count = 3.
- **Bad checksum:** start, 02, 10, 20, csum 31 (expected 30) → 2 writes occur, then err = 1, done = 0, cpu_rst stays 1.
- **Bad length:**
  - Length 00 → ERR with no writes.
  - Separately, length 21h (33) → ERR with no writes.
- **Backpressure:**
  - Stimulus: good 32-byte load with in_valid toggling every other cycle.
  - Writes: exactly 32 writes, to addresses 0..31 in order, with no duplicates.
  - Result: done = 1.
- **Reload and mid-load reset:**
  - From DONE, start a new load, then pulse rst after 2 payload bytes.
  - Required: IDLE state, cpu_rst = 1, no further writes, and start ignored until rst is low.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared sizing constants and state encoding for the instruction-memory boot loader.
package imem_pkg;

   localparam int unsigned DEPTH  = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StLen  = 3'd1,
      StData = 3'd2,
      StCsum = 3'd3,
      StDone = 3'd4,
      StErr  = 3'd5
   } state_t;

endpackage

// File: rtl/imem_loader.sv
// Boot-time loader: takes a framed byte stream (length, payload, XOR checksum) and writes the
// payload into instruction RAM from address 0, holding the CPU in reset until a good load.
module imem_loader #(
   parameter int unsigned DEPTH  = imem_pkg::DEPTH,
   parameter int unsigned ADDR_W = imem_pkg::ADDR_W,
   parameter int unsigned DATA_W = imem_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              cpu_rst,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   import imem_pkg::*;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic                in_ready_q, in_ready_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                cpu_rst_q, cpu_rst_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                accept;
   logic                len_ok;

   // in_ready_q always mirrors the current state, so it doubles as the handshake gate
   assign accept = in_valid && in_ready_q;
   assign len_ok = (in_data != '0) && (32'(in_data) <= DEPTH);

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      count_d   = count_q;
      len_d     = len_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      unique case (state_q)
         StIdle, StDone, StErr: begin
            if (start) begin
               state_d = StLen;
               count_d = '0;
               acc_d   = '0;
            end
         end
         StLen: begin
            if (accept) begin
               if (len_ok) begin
                  state_d = StData;
                  len_d   = in_data[ADDR_W:0];
                  count_d = '0;
                  acc_d   = '0;
               end else begin
                  state_d = StErr;
               end
            end
         end
         StData: begin
            if (accept) begin
               wr_en_d   = 1'b1;
               wr_addr_d = count_q[ADDR_W-1:0];
               wr_data_d = in_data;
               acc_d     = acc_q ^ in_data;
               count_d   = count_q + 1'b1;
               if (count_d == len_q) begin
                  state_d = StCsum;
               end
            end
         end
         StCsum: begin
            if (accept) begin
               state_d = (in_data == acc_q) ? StDone : StErr;
            end
         end
         default: state_d = StIdle;
      endcase

      // Status flags are registered from the next state so they move on the deciding edge
      in_ready_d = (state_d == StLen) || (state_d == StData) || (state_d == StCsum);
      cpu_rst_d  = (state_d != StDone);
      done_d     = (state_d == StDone);
      err_d      = (state_d == StErr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         acc_q      <= '0;
         count_q    <= '0;
         len_q      <= '0;
         in_ready_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         cpu_rst_q  <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         count_q    <= count_d;
         len_q      <= len_d;
         in_ready_q <= in_ready_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         cpu_rst_q  <= cpu_rst_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign in_ready = in_ready_q;
   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign cpu_rst  = cpu_rst_q;
   assign done     = done_q;
   assign err      = err_q;
   assign count    = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected RAM writes are queued as bytes are offered and
// checked against the write port as it fires.
module tb_imem_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic       wr_en;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic       cpu_rst;
   logic       done;
   logic       err;
   logic [5:0] count;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int n_writes = 0;
   logic [12:0] exp_q[$];
   int wr_cyc[$];

   imem_loader dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cpu_rst  (cpu_rst),
      .done     (done),
      .err      (err),
      .count    (count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Write-port monitor: every strobe must match the oldest queued expectation
   always @(negedge clk) begin
      if (wr_en) begin
         n_writes++;
         wr_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(exp_q.size()), 32'd1);
         end else begin
            logic [12:0] e;
            e = exp_q.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(e[12:8]));
            check("wr_data", 32'(wr_data), 32'(e[7:0]));
         end
      end
   end

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offer one byte; returns at the negedge after the accepting edge
   task automatic send(input logic [7:0] b, input bit is_payload, input logic [4:0] addr);
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("ready_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      if (is_payload) exp_q.push_back({addr, b});
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      logic [7:0] cs;
      logic [7:0] b;

      // Reset state
      #12;
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_cpu_rst", 32'(cpu_rst), 1);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_count", 32'(count), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 0);

      // Good load; first byte already valid during the start cycle
      wr_cyc.delete();
      in_valid = 1'b1;
      in_data  = 8'h03;
      do_start();
      send(8'h03, 0, 0);
      send(8'h0B, 1, 0);
      send(8'h49, 1, 1);
      send(8'h12, 1, 2);
      send(8'h50, 0, 0);
      check("good_done", 32'(done), 1);
      check("good_err", 32'(err), 0);
      check("good_cpu_rst", 32'(cpu_rst), 0);
      check("good_count", 32'(count), 3);
      check("good_in_ready_drop", 32'(in_ready), 0);
      check("good_nwrites", 32'(wr_cyc.size()), 3);
      if (wr_cyc.size() == 3) check("good_consecutive", 32'(wr_cyc[2] - wr_cyc[0]), 2);
      check("good_queue_empty", 32'(exp_q.size()), 0);

      // Bad checksum
      do_start();
      check("restart_done_clr", 32'(done), 0);
      check("restart_count_clr", 32'(count), 0);
      send(8'h02, 0, 0);
      send(8'h10, 1, 0);
      send(8'h20, 1, 1);
      send(8'h31, 0, 0);
      check("badcs_err", 32'(err), 1);
      check("badcs_done", 32'(done), 0);
      check("badcs_cpu_rst", 32'(cpu_rst), 1);
      check("badcs_count", 32'(count), 2);

      // Bad lengths 0 and 33
      w0 = n_writes;
      do_start();
      send(8'h00, 0, 0);
      repeat (3) @(negedge clk);
      check("len0_err", 32'(err), 1);
      check("len0_in_ready", 32'(in_ready), 0);
      check("len0_nowrites", 32'(n_writes - w0), 0);
      do_start();
      check("len33_err_clr", 32'(err), 0);
      send(8'h21, 0, 0);
      repeat (3) @(negedge clk);
      check("len33_err", 32'(err), 1);
      check("len33_done", 32'(done), 0);
      check("len33_nowrites", 32'(n_writes - w0), 0);

      // Full-depth load with a gap after every byte
      w0 = n_writes;
      cs = 8'h00;
      do_start();
      send(8'h20, 0, 0);
      @(negedge clk);
      for (int i = 0; i < 32; i++) begin
         b  = 8'(i * 37 + 5);
         cs = cs ^ b;
         send(b, 1, 5'(i));
         @(negedge clk);
      end
      send(cs, 0, 0);
      check("bp_done", 32'(done), 1);
      check("bp_count", 32'(count), 32);
      check("bp_nwrites", 32'(n_writes - w0), 32);
      check("bp_queue_empty", 32'(exp_q.size()), 0);

      // Reload from DONE, then reset after two payload bytes
      w0 = n_writes;
      do_start();
      check("reload_cpu_rst", 32'(cpu_rst), 1);
      send(8'h05, 0, 0);
      send(8'hA1, 1, 0);
      send(8'hA2, 1, 1);
      in_valid = 1'b1;
      in_data  = 8'hA3;
      #2 rst = 1'b1;
      #1;
      check("mid_rst_in_ready", 32'(in_ready), 0);
      check("mid_rst_wr_en", 32'(wr_en), 0);
      check("mid_rst_cpu_rst", 32'(cpu_rst), 1);
      check("mid_rst_done", 32'(done), 0);
      check("mid_rst_err", 32'(err), 0);
      check("mid_rst_count", 32'(count), 0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rst = 1'b0;
      repeat (4) @(negedge clk);
      in_valid = 1'b0;
      check("post_rst_in_ready", 32'(in_ready), 0);
      check("post_rst_cpu_rst", 32'(cpu_rst), 1);
      check("post_rst_writes", 32'(n_writes - w0), 2);
      check("post_rst_queue", 32'(exp_q.size()), 0);

      // Fresh single-byte load from IDLE
      do_start();
      send(8'h01, 0, 0);
      send(8'hAA, 1, 0);
      send(8'hAA, 0, 0);
      check("one_done", 32'(done), 1);
      check("one_count", 32'(count), 1);
      check("one_cpu_rst", 32'(cpu_rst), 0);
      repeat (2) @(negedge clk);
      check("final_queue", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
